// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared MIPS core types: ALU op classes, default widths, control bundle
package cpu_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int REG_ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_SUB  = 2'b01,
    ALU_RTYP = 2'b10,
    ALU_RSVD = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_pipe_reg_sat_counter.sv
// rtl/id_ex_pipe_reg_sat_counter.sv - saturating up-counter (module sat_counter), async active-low reset
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (en && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with stall/flush; ID_EX_BUBBLE_CNT_EN adds bubble_cnt
module id_ex_pipe_reg
  import cpu_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic                  id_reg_dst,
  input  logic                  id_alu_src,
  input  logic                  id_mem_to_reg,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_branch,
  input  logic [1:0]            id_alu_op,
  input  logic [DATA_W-1:0]     id_pc_plus4,
  input  logic [DATA_W-1:0]     id_rdata1,
  input  logic [DATA_W-1:0]     id_rdata2,
  input  logic [DATA_W-1:0]     id_imm_ext,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  output logic                  ex_valid,
  output logic                  ex_reg_dst,
  output logic                  ex_alu_src,
  output logic                  ex_mem_to_reg,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_branch,
  output logic [1:0]            ex_alu_op,
  output logic [DATA_W-1:0]     ex_pc_plus4,
  output logic [DATA_W-1:0]     ex_rdata1,
  output logic [DATA_W-1:0]     ex_rdata2,
  output logic [DATA_W-1:0]     ex_imm_ext,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_rd
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [CNT_W-1:0]      bubble_cnt
`endif
);

  ctrl_t                 w_id_ctrl;
  ctrl_t                 w_load_ctrl;
  logic                  w_load;
  logic                  w_bubble_event;

  ctrl_t                 r_ctrl;
  logic                  r_valid;
  logic [DATA_W-1:0]     r_pc_plus4;
  logic [DATA_W-1:0]     r_rdata1;
  logic [DATA_W-1:0]     r_rdata2;
  logic [DATA_W-1:0]     r_imm_ext;
  logic [REG_ADDR_W-1:0] r_rs;
  logic [REG_ADDR_W-1:0] r_rt;
  logic [REG_ADDR_W-1:0] r_rd;

  assign w_id_ctrl = '{
    reg_dst:    id_reg_dst,
    alu_src:    id_alu_src,
    mem_to_reg: id_mem_to_reg,
    reg_write:  id_reg_write,
    mem_read:   id_mem_read,
    mem_write:  id_mem_write,
    branch:     id_branch,
    alu_op:     id_alu_op
  };

  // An invalid ID slot still carries its data, but must never write state downstream.
  assign w_load_ctrl    = id_valid ? w_id_ctrl : CTRL_NOP;
  assign w_load         = !flush && !stall;
  assign w_bubble_event = flush || (w_load && !id_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl     <= CTRL_NOP;
      r_valid    <= 1'b0;
      r_pc_plus4 <= '0;
      r_rdata1   <= '0;
      r_rdata2   <= '0;
      r_imm_ext  <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
    end else if (flush) begin
      r_ctrl     <= CTRL_NOP;
      r_valid    <= 1'b0;
      r_pc_plus4 <= '0;
      r_rdata1   <= '0;
      r_rdata2   <= '0;
      r_imm_ext  <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
    end else if (w_load) begin
      r_ctrl     <= w_load_ctrl;
      r_valid    <= id_valid;
      r_pc_plus4 <= id_pc_plus4;
      r_rdata1   <= id_rdata1;
      r_rdata2   <= id_rdata2;
      r_imm_ext  <= id_imm_ext;
      r_rs       <= id_rs;
      r_rt       <= id_rt;
      r_rd       <= id_rd;
    end
  end

  assign ex_valid      = r_valid;
  assign ex_reg_dst    = r_ctrl.reg_dst;
  assign ex_alu_src    = r_ctrl.alu_src;
  assign ex_mem_to_reg = r_ctrl.mem_to_reg;
  assign ex_reg_write  = r_ctrl.reg_write;
  assign ex_mem_read   = r_ctrl.mem_read;
  assign ex_mem_write  = r_ctrl.mem_write;
  assign ex_branch     = r_ctrl.branch;
  assign ex_alu_op     = r_ctrl.alu_op;
  assign ex_pc_plus4   = r_pc_plus4;
  assign ex_rdata1     = r_rdata1;
  assign ex_rdata2     = r_rdata2;
  assign ex_imm_ext    = r_imm_ext;
  assign ex_rs         = r_rs;
  assign ex_rt         = r_rt;
  assign ex_rd         = r_rd;

`ifdef ID_EX_BUBBLE_CNT_EN
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_bubble_event),
    .count (bubble_cnt)
  );
`else
  logic w_unused_bubble;
  assign w_unused_bubble = w_bubble_event & (CNT_W > 0);
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - scoreboard testbench for id_ex_pipe_reg
module tb_id_ex_pipe_reg;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, id_valid;
  logic        id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write;
  logic        id_mem_read, id_mem_write, id_branch;
  logic [1:0]  id_alu_op;
  logic [31:0] id_pc_plus4, id_rdata1, id_rdata2, id_imm_ext;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        ex_valid, ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write;
  logic        ex_mem_read, ex_mem_write, ex_branch;
  logic [1:0]  ex_alu_op;
  logic [31:0] ex_pc_plus4, ex_rdata1, ex_rdata2, ex_imm_ext;
  logic [4:0]  ex_rs, ex_rt, ex_rd;

  int checks = 0;
  int errors = 0;
  logic [152:0] sb_q[$];
  logic [152:0] m_state;
  logic [152:0] held;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt, m_cnt;
  logic [1:0]  bubble_cnt2, m_cnt2;
  logic        ex2_valid, ex2_reg_dst, ex2_alu_src, ex2_mem_to_reg, ex2_reg_write;
  logic        ex2_mem_read, ex2_mem_write, ex2_branch;
  logic [1:0]  ex2_alu_op;
  logic [31:0] ex2_pc_plus4, ex2_rdata1, ex2_rdata2, ex2_imm_ext;
  logic [4:0]  ex2_rs, ex2_rt, ex2_rd;
`endif

  always #5 clk = ~clk;

  id_ex_pipe_reg dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_reg_dst(id_reg_dst), .id_alu_src(id_alu_src), .id_mem_to_reg(id_mem_to_reg),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_branch(id_branch), .id_alu_op(id_alu_op), .id_pc_plus4(id_pc_plus4),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm_ext(id_imm_ext),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_valid(ex_valid), .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_alu_op(ex_alu_op),
    .ex_pc_plus4(ex_pc_plus4), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2),
    .ex_imm_ext(ex_imm_ext), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd)
`ifdef ID_EX_BUBBLE_CNT_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

`ifdef ID_EX_BUBBLE_CNT_EN
  id_ex_pipe_reg #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_reg_dst(id_reg_dst), .id_alu_src(id_alu_src), .id_mem_to_reg(id_mem_to_reg),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_branch(id_branch), .id_alu_op(id_alu_op), .id_pc_plus4(id_pc_plus4),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm_ext(id_imm_ext),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_valid(ex2_valid), .ex_reg_dst(ex2_reg_dst), .ex_alu_src(ex2_alu_src),
    .ex_mem_to_reg(ex2_mem_to_reg), .ex_reg_write(ex2_reg_write), .ex_mem_read(ex2_mem_read),
    .ex_mem_write(ex2_mem_write), .ex_branch(ex2_branch), .ex_alu_op(ex2_alu_op),
    .ex_pc_plus4(ex2_pc_plus4), .ex_rdata1(ex2_rdata1), .ex_rdata2(ex2_rdata2),
    .ex_imm_ext(ex2_imm_ext), .ex_rs(ex2_rs), .ex_rt(ex2_rt), .ex_rd(ex2_rd),
    .bubble_cnt(bubble_cnt2)
  );
`endif

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [152:0] id_vec();
    return {id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read, id_mem_write,
            id_branch, id_alu_op, id_valid, id_pc_plus4, id_rdata1, id_rdata2, id_imm_ext,
            id_rs, id_rt, id_rd};
  endfunction

  function automatic logic [152:0] ex_vec();
    return {ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read, ex_mem_write,
            ex_branch, ex_alu_op, ex_valid, ex_pc_plus4, ex_rdata1, ex_rdata2, ex_imm_ext,
            ex_rs, ex_rt, ex_rd};
  endfunction

  task automatic rnd_id();
    {id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write} = 4'($urandom);
    {id_mem_read, id_mem_write, id_branch} = 3'($urandom);
    id_alu_op   = 2'($urandom);
    id_pc_plus4 = $urandom;
    id_rdata1   = $urandom;
    id_rdata2   = $urandom;
    id_imm_ext  = $urandom;
    id_rs       = 5'($urandom);
    id_rt       = 5'($urandom);
    id_rd       = 5'($urandom);
  endtask

  task automatic model_reset();
    m_state = '0;
`ifdef ID_EX_BUBBLE_CNT_EN
    m_cnt  = '0;
    m_cnt2 = '0;
`endif
  endtask

  // Push the expected post-edge state, advance one edge, then pop and compare.
  task automatic cycle();
    logic [152:0] nxt;
    logic [152:0] exp;
    nxt = id_vec();
    if (!id_valid) nxt[152:144] = '0;
    if (flush) m_state = '0;
    else if (!stall) m_state = nxt;
`ifdef ID_EX_BUBBLE_CNT_EN
    if (flush || (!stall && !id_valid)) begin
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1'b1;
      if (m_cnt2 != 2'b11) m_cnt2 = m_cnt2 + 1'b1;
    end
`endif
    sb_q.push_back(m_state);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 160'd1, 160'd0);
    end else begin
      exp = sb_q.pop_front();
      check("ex_fields", {7'd0, ex_vec()}, {7'd0, exp});
    end
`ifdef ID_EX_BUBBLE_CNT_EN
    check("bubble_cnt", {144'd0, bubble_cnt}, {144'd0, m_cnt});
    check("bubble_cnt_w2", {158'd0, bubble_cnt2}, {158'd0, m_cnt2});
`endif
  endtask

  task automatic async_reset_pulse();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_reset", {7'd0, ex_vec()}, 160'd0);
`ifdef ID_EX_BUBBLE_CNT_EN
    check("async_reset_cnt", {144'd0, bubble_cnt}, 160'd0);
`endif
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
    {id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read, id_mem_write, id_branch} = '0;
    id_alu_op = '0; id_pc_plus4 = '0; id_rdata1 = '0; id_rdata2 = '0; id_imm_ext = '0;
    id_rs = '0; id_rt = '0; id_rd = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {7'd0, ex_vec()}, 160'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    rnd_id(); id_valid = 1'b1; id_imm_ext = 32'hFFFF_FF80;
    cycle();
    check("imm_neg", {128'd0, ex_imm_ext}, {128'd0, 32'hFFFF_FF80});

    rnd_id(); id_valid = 1'b1; id_rdata1 = 32'h0000_1234; id_rt = 5'd9; id_reg_write = 1'b1;
    cycle();
    check("load_rdata1", {128'd0, ex_rdata1}, {128'd0, 32'h0000_1234});
    check("load_rt", {155'd0, ex_rt}, {155'd0, 5'd9});
    check("load_reg_write", {159'd0, ex_reg_write}, 160'd1);
    check("load_valid", {159'd0, ex_valid}, 160'd1);

    async_reset_pulse();

    rnd_id(); id_valid = 1'b1;
    cycle();
    held = ex_vec();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rnd_id(); id_valid = 1'(i);
      cycle();
      check("stall_hold", {7'd0, ex_vec()}, {7'd0, held});
    end
    stall = 1'b0; rnd_id(); id_valid = 1'b1;
    cycle();

    rnd_id(); id_valid = 1'b1; id_mem_write = 1'b1; flush = 1'b1;
    cycle();
    check("flush_mem_write", {159'd0, ex_mem_write}, 160'd0);
    check("flush_valid", {159'd0, ex_valid}, 160'd0);
    check("flush_imm", {128'd0, ex_imm_ext}, 160'd0);
    flush = 1'b0;

    rnd_id(); id_valid = 1'b1;
    cycle();
    stall = 1'b1; flush = 1'b1; rnd_id();
    cycle();
    check("flush_over_stall", {159'd0, ex_valid}, 160'd0);
    stall = 1'b0; flush = 1'b0;

    rnd_id(); id_valid = 1'b0;
    {id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read, id_mem_write, id_branch} = '1;
    id_alu_op = 2'b11; id_rdata2 = 32'hCAFE_F00D;
    cycle();
    check("invalid_ctrl", {151'd0, ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write,
                           ex_mem_read, ex_mem_write, ex_branch, ex_alu_op}, 160'd0);
    check("invalid_data", {128'd0, ex_rdata2}, {128'd0, 32'hCAFE_F00D});

    for (int i = 0; i < 40; i++) begin
      rnd_id();
      id_valid = 1'($urandom);
      stall    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 5) == 0);
      cycle();
    end
    stall = 1'b0; flush = 1'b0;

    async_reset_pulse();
    id_valid = 1'b1;
    flush = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rnd_id();
      cycle();
    end
    flush = 1'b0; stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rnd_id();
      cycle();
    end
    stall = 1'b0;
`ifdef ID_EX_BUBBLE_CNT_EN
    check("bubble_five", {144'd0, bubble_cnt}, {144'd0, 16'd5});
    check("bubble_sat_w2", {158'd0, bubble_cnt2}, {158'd0, 2'd3});
`endif
    check("sb_drained", {128'd0, 32'(sb_q.size())}, 160'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
